// File: rtl/arb_pkg.sv
// Shared definitions for the bus round-robin arbiter: FSM encoding and sizing constants.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_N = 5;
  localparam int IDX_W     = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first unmasked request at or after start, modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N-1:0]     pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [N-1:0] cand;
  logic         found;
  int           j;

  assign cand = req_i & ~mask_i;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      // start_i is always below N, so a single subtraction wraps the scan
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!found && ((cand & (N'(1) << j)) != '0)) begin
        found  = 1'b1;
        pick_o = N'(1) << j;
        idx_o  = IDX_W'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one bus slave among N requesters; grant held per transaction
// and released on bus_done or watchdog expiry, with back-to-back re-arbitration.
module bus_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             bus_done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       wdog_q, wdog_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_start;
  logic [N-1:0]     pick_mask;
  logic [N-1:0]     pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             wdog_exp;
  logic             release_now;

  assign next_ptr    = (int'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;
  assign wdog_exp    = (wdog_q == 8'(TIMEOUT - 1));
  assign release_now = (state_q == GRANT) && (bus_done || wdog_exp);

  // One picker serves both the idle scan and the release-cycle re-arbitration
  assign pick_start = (state_q == GRANT) ? next_ptr : ptr_q;
  assign pick_mask  = (state_q == GRANT) ? grant_q  : '0;

  rr_pick #(.N(N)) u_pick (
    .req_i   (req),
    .mask_i  (pick_mask),
    .start_i (pick_start),
    .pick_o  (pick_oh),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_oh;
          idx_d   = pick_idx;
          wdog_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = next_ptr;
          wdog_d    = '0;
          timeout_d = !bus_done;
          if (pick_vld) begin
            grant_d = pick_oh;
            idx_d   = pick_idx;
          end else begin
            grant_d = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      wdog_q    <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic, scored against a queue-fed model.
module tb_bus_rr_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic           bus_done = 1'b0;
  logic [N-1:0]   grant;
  logic [2:0]     grant_idx;
  logic           busy;
  logic           timeout;

  bus_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bus_done  (bus_done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [2:0]   idx;
    logic         busy;
    logic         to;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: current owner (-1 = nobody), rotation pointer, cycles held
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_held  = 0;

  function automatic int first_from(input logic [N-1:0] r, input int start);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (start + k) % N;
      if ((r & (N'(1) << j)) != '0) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic done);
    exp_t e;
    logic to;
    to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      m_owner = first_from(rq, m_ptr);
      m_held  = 0;
    end else if (done || m_held == TIMEOUT - 1) begin
      to      = !done;
      m_ptr   = (m_owner + 1) % N;
      m_owner = first_from(rq & ~(N'(1) << m_owner), m_ptr);
      m_held  = 0;
    end else begin
      m_held++;
    end
    e.grant = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    e.idx   = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    e.busy  = (m_owner >= 0);
    e.to    = to;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic done);
    @(negedge clk);
    rst      = r;
    req      = rq;
    bus_done = done;
    model_step(r, rq, done);
  endtask

  task automatic chk_now(input string name, input logic [N-1:0] eg, input logic eto);
    @(posedge clk);
    #2;
    n_checks++;
    if (grant !== eg || timeout !== eto || busy !== (eg != '0)) begin
      n_errors++;
      $display("FAIL %s: got grant=%b timeout=%b busy=%b, expected grant=%b timeout=%b busy=%b",
               name, grant, timeout, busy, eg, eto, (eg != '0));
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({grant, grant_idx, busy, timeout} !== e) begin
          n_errors++;
          $display("FAIL scoreboard t=%0t: got grant=%b idx=%0d busy=%b to=%b, expected grant=%b idx=%0d busy=%b to=%b",
                   $time, grant, grant_idx, busy, timeout, e.grant, e.idx, e.busy, e.to);
        end
        n_checks++;
        if ($countones(grant) > 1) begin
          n_errors++;
          $display("FAIL onehot t=%0t: grant=%b, expected at most one bit set", $time, grant);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] rot [4];
    rot[0] = 4'b0010; rot[1] = 4'b0100; rot[2] = 4'b1000; rot[3] = 4'b0001;

    // Reset held with all requests pending
    cycle(1'b1, 4'b1111, 1'b0); chk_now("reset_c1", 4'b0000, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0); chk_now("reset_c2", 4'b0000, 1'b0);
    cycle(1'b0, 4'b1111, 1'b0); chk_now("first_grant", 4'b0001, 1'b0);

    // Rotation with bus_done in the third cycle of each grant
    for (int g = 0; g < 4; g++) begin
      cycle(1'b0, 4'b1111, 1'b0); chk_now("rot_hold2", (g == 0) ? 4'b0001 : rot[g-1], 1'b0);
      cycle(1'b0, 4'b1111, 1'b0); chk_now("rot_hold3", (g == 0) ? 4'b0001 : rot[g-1], 1'b0);
      cycle(1'b0, 4'b1111, 1'b1); chk_now("rot_next", rot[g], 1'b0);
    end

    // Hold and ignore: grantee drops req, another raises; grant must not move
    cycle(1'b1, 4'b0000, 1'b0); chk_now("reset2", 4'b0000, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0); chk_now("hold_grant", 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b0001, 1'b0); chk_now("hold_ignore_drop", 4'b0100, 1'b0);
    end
    cycle(1'b0, 4'b0001, 1'b1); chk_now("hold_wrap_to0", 4'b0001, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1); chk_now("hold_release", 4'b0000, 1'b0);

    // Release to idle, then bus_done while idle
    cycle(1'b0, 4'b0010, 1'b0); chk_now("idle_grant", 4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b0010, 1'b0); chk_now("idle_hold", 4'b0010, 1'b0);
    end
    cycle(1'b0, 4'b0010, 1'b1); chk_now("idle_released", 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b1); chk_now("idle_done_ignored", 4'b0000, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0); chk_now("idle_stays", 4'b0000, 1'b0);

    // Watchdog expiry, then bus_done on the final allowed cycle
    cycle(1'b1, 4'b0000, 1'b0); chk_now("reset3", 4'b0000, 1'b0);
    cycle(1'b0, 4'b0011, 1'b0); chk_now("wd_grant", 4'b0001, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      cycle(1'b0, 4'b0011, 1'b0); chk_now("wd_hold", 4'b0001, 1'b0);
    end
    cycle(1'b0, 4'b0011, 1'b0); chk_now("wd_expire", 4'b0010, 1'b1);
    cycle(1'b0, 4'b0011, 1'b0); chk_now("wd_pulse_end", 4'b0010, 1'b0);
    for (int i = 0; i < TIMEOUT - 2; i++) begin
      cycle(1'b0, 4'b0011, 1'b0); chk_now("wd_hold2", 4'b0010, 1'b0);
    end
    cycle(1'b0, 4'b0011, 1'b1); chk_now("wd_done_wins", 4'b0001, 1'b0);

    // Mid-transaction reset must also clear the rotation pointer
    cycle(1'b0, 4'b1000, 1'b1); chk_now("mid_grant3", 4'b1000, 1'b0);
    cycle(1'b0, 4'b1000, 1'b0); chk_now("mid_hold3", 4'b1000, 1'b0);
    cycle(1'b1, 4'b1001, 1'b0); chk_now("mid_reset", 4'b0000, 1'b0);
    cycle(1'b0, 4'b1001, 1'b0); chk_now("mid_after_reset", 4'b0001, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rq = N'($urandom);
      cycle(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
